// File: rtl/hi_lo_muldiv_unit.sv
// hi_lo_muldiv_unit
//   Write side of the HI/LO special registers. Executes MULT/MULTU/DIV/DIVU and
//   MTHI/MTLO issued from execute, holds HI/LO and drives them to the decode-stage
//   register-file mux. busy tells the hazard unit to stall MFHI/MFLO and further
//   HI/LO ops until the in-flight result has been committed.
//
// Ports
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   start        in   1   op valid this cycle; accepted only while busy is low
//   op           in   3   0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6/7=no-op
//   operand_a    in   32  rs value (multiplicand / dividend / MTHI-MTLO source)
//   operand_b    in   32  rt value (multiplier / divisor)
//   cancel       in   1   pipeline flush: abort in-flight op, HI/LO untouched
//   busy         out  1   op in flight; HI/LO not yet valid for it
//   done         out  1   one-cycle pulse the cycle after a MULT/DIV commit
//   HI_data_reg  out  32  current HI
//   LO_data_reg  out  32  current LO

module hi_lo_muldiv_unit #(
  parameter int MULT_LATENCY = 4,
  parameter int DIV_CYCLES   = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI_data_reg,
  output logic [31:0] LO_data_reg
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_LATENCY) ? DIV_CYCLES : MULT_LATENCY;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DIV_BUSY = 2'd2
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   counter_q;
  logic               busy_q;
  logic               done_q;
  logic [31:0]        hi_q;
  logic [31:0]        lo_q;
  logic [31:0]        opa_q;
  logic [31:0]        opb_q;
  logic               mulSigned_q;
  logic [31:0]        rem_q;
  logic [31:0]        quo_q;
  logic [31:0]        divisor_q;
  logic               negQuot_q;
  logic               negRem_q;
  logic               divZero_q;

  logic [63:0]        mulExtA;
  logic [63:0]        mulExtB;
  logic [63:0]        product_d;
  logic               aNeg;
  logic               bNeg;
  logic [32:0]        divShift;
  logic               divFits;
  logic [31:0]        remNext_d;
  logic [31:0]        quoNext_d;
  logic [31:0]        quoFinal;
  logic [31:0]        remFinal;

  // Datapath: the multiply is a multicycle path from the latched operands to the
  // commit edge. The divider shifts the dividend magnitude out of quo_q one bit per
  // iteration while quotient bits shift in from the bottom.
  always_comb begin
    mulExtA   = mulSigned_q ? {{32{opa_q[31]}}, opa_q} : {32'b0, opa_q};
    mulExtB   = mulSigned_q ? {{32{opb_q[31]}}, opb_q} : {32'b0, opb_q};
    product_d = mulExtA * mulExtB;

    aNeg = (op == OP_DIV) && operand_a[31];
    bNeg = (op == OP_DIV) && operand_b[31];

    divShift  = {rem_q, quo_q[31]};
    divFits   = (divShift >= {1'b0, divisor_q});
    // When the divisor fits, the true difference is below the divisor and so fits in 32 bits.
    remNext_d = divFits ? (divShift[31:0] - divisor_q) : divShift[31:0];
    quoNext_d = {quo_q[30:0], divFits};

    quoFinal = negQuot_q ? -quo_q : quo_q;
    remFinal = negRem_q  ? -rem_q : rem_q;
  end

  // Control FSM and all architectural state. cancel takes priority over both
  // acceptance and commit, so a flush never lets a result reach HI/LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      counter_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      mulSigned_q <= 1'b0;
      rem_q       <= '0;
      quo_q       <= '0;
      divisor_q   <= '0;
      negQuot_q   <= 1'b0;
      negRem_q    <= 1'b0;
      divZero_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !cancel) begin
            case (op)
              OP_MTHI: hi_q <= operand_a;
              OP_MTLO: lo_q <= operand_a;
              OP_MULT, OP_MULTU: begin
                opa_q       <= operand_a;
                opb_q       <= operand_b;
                mulSigned_q <= (op == OP_MULT);
                counter_q   <= CNT_W'(MULT_LATENCY - 1);
                busy_q      <= 1'b1;
                state_q     <= MUL_BUSY;
              end
              OP_DIV, OP_DIVU: begin
                // Magnitudes are divided; signs are restored on the commit edge.
                opa_q     <= operand_a;
                quo_q     <= aNeg ? -operand_a : operand_a;
                divisor_q <= bNeg ? -operand_b : operand_b;
                rem_q     <= '0;
                negQuot_q <= aNeg ^ bNeg;
                negRem_q  <= aNeg;
                divZero_q <= (operand_b == 32'd0);
                counter_q <= CNT_W'(DIV_CYCLES - 1);
                busy_q    <= 1'b1;
                state_q   <= DIV_BUSY;
              end
              default: ;
            endcase
          end
        end

        MUL_BUSY: begin
          if (cancel) begin
            counter_q <= '0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else if (counter_q == '0) begin
            hi_q    <= product_d[63:32];
            lo_q    <= product_d[31:0];
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            counter_q <= counter_q - 1'b1;
          end
        end

        DIV_BUSY: begin
          if (cancel) begin
            counter_q <= '0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else if (counter_q == '0) begin
            // Final cycle: sign fixup, or the fixed divide-by-zero result.
            if (divZero_q) begin
              hi_q <= opa_q;
              lo_q <= 32'hFFFF_FFFF;
            end else begin
              hi_q <= remFinal;
              lo_q <= quoFinal;
            end
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            rem_q     <= remNext_d;
            quo_q     <= quoNext_d;
            counter_q <= counter_q - 1'b1;
          end
        end

        default: begin
          counter_q <= '0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign HI_data_reg = hi_q;
  assign LO_data_reg = lo_q;

endmodule
